gip_sram_burst_master: RTL and testbench

Initiator for the 2048 x 32-bit byte-writable single-port SRAM macro used by the gip_ddr emulation build. It accepts read and write burst requests over a valid/ack handshake and drives the SRAM port's read_not_write, byte write enable, address and data pins. Write data arrives through a per-beat valid/ack stream. Read data returns through a registered valid stream, which hides the SRAM's one-cycle read latency from client logic.

---
 rtl/gip_sram_burst_master.sv | 150 +++++++++++++++
 tb/tb_gip_sram_burst_master.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gip_sram_burst_master.sv
`default_nettype none
// ============================================================================
// gip_sram_burst_master : read/write burst initiator for a 2048x32 byte-
// writable single-port SRAM, with a registered read-return stream.
// Revision: 1.0
// ============================================================================
module gip_sram_burst_master (
  input  logic        sram_clock,
  input  logic        sram_reset,
  input  logic        req_valid,
  output logic        req_ack,
  input  logic        req_read_not_write,
  input  logic [10:0] req_address,
  input  logic [3:0]  req_burst_length,
  input  logic [3:0]  req_byte_enables,
  input  logic        wr_data_valid,
  input  logic [31:0] wr_data,
  output logic        wr_data_ack,
  output logic        rd_data_valid,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic        sram_read_not_write,
  output logic [3:0]  sram_write_enable,
  output logic [10:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [31:0] sram_read_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] addr_q, addr_d;
  logic [10:0] hold_q, hold_d;
  logic [3:0]  beats_q, beats_d;
  logic [3:0]  be_q, be_d;
  logic        s1_valid_q, s1_valid_d;
  logic        s1_last_q, s1_last_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_last_q, rd_last_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        beat;

  always_comb begin
    state_d             = state_q;
    addr_d              = addr_q;
    hold_d              = hold_q;
    beats_d             = beats_q;
    be_d                = be_q;
    s1_valid_d          = 1'b0;
    s1_last_d           = 1'b0;
    beat                = 1'b0;
    req_ack             = 1'b0;
    wr_data_ack         = 1'b0;
    sram_read_not_write = 1'b1;
    sram_write_enable   = 4'h0;
    sram_address        = hold_q;
    sram_write_data     = 32'h0;

    case (state_q)
      ST_IDLE: begin
        req_ack = req_valid;
        if (req_valid) begin
          addr_d  = req_address;
          beats_d = req_burst_length;
          be_d    = req_byte_enables;
          state_d = req_read_not_write ? ST_READ : ST_WRITE;
        end
      end
      ST_READ: begin
        sram_address = addr_q;
        hold_d       = addr_q;
        beat         = 1'b1;
        s1_valid_d   = 1'b1;
        s1_last_d    = (beats_q == 4'd0);
      end
      ST_WRITE: begin
        sram_address = addr_q;
        hold_d       = addr_q;
        if (wr_data_valid) begin
          beat                = 1'b1;
          wr_data_ack         = 1'b1;
          sram_read_not_write = 1'b0;
          sram_write_enable   = be_q;
          sram_write_data     = wr_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The 11-bit counter wraps 2047 -> 0 on its own.
    if (beat) begin
      addr_d = addr_q + 11'd1;
      if (beats_q == 4'd0) begin
        state_d = ST_IDLE;
      end else begin
        beats_d = beats_q - 4'd1;
      end
    end

    // Return stage runs regardless of FSM state so reads drain under new work.
    rd_valid_d = s1_valid_q;
    rd_last_d  = s1_last_q;
    rd_data_d  = s1_valid_q ? sram_read_data : 32'h0;

    if (sram_reset) begin
      req_ack             = 1'b0;
      wr_data_ack         = 1'b0;
      sram_read_not_write = 1'b1;
      sram_write_enable   = 4'h0;
      sram_address        = 11'd0;
      sram_write_data     = 32'h0;
    end
  end

  always_ff @(posedge sram_clock) begin
    if (sram_reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= 11'd0;
      hold_q     <= 11'd0;
      beats_q    <= 4'd0;
      be_q       <= 4'h0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      hold_q     <= hold_d;
      beats_q    <= beats_d;
      be_q       <= be_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data_valid = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign rd_last       = rd_last_q;

endmodule
`default_nettype wire

// File: tb/tb_gip_sram_burst_master.sv
`default_nettype none
// ============================================================================
// tb_gip_sram_burst_master : transaction-level model plus directed bursts.
// Revision: 1.0
// ============================================================================
module tb_gip_sram_burst_master;

  logic        clk = 1'b0;
  logic        sram_reset;
  logic        req_valid, req_ack, req_read_not_write;
  logic [10:0] req_address;
  logic [3:0]  req_burst_length, req_byte_enables;
  logic        wr_data_valid, wr_data_ack;
  logic [31:0] wr_data;
  logic        rd_data_valid, rd_last;
  logic [31:0] rd_data;
  logic        sram_read_not_write;
  logic [3:0]  sram_write_enable;
  logic [10:0] sram_address;
  logic [31:0] sram_write_data, sram_read_data;

  always #5 clk = ~clk;

  gip_sram_burst_master dut (
    .sram_clock(clk), .sram_reset(sram_reset),
    .req_valid(req_valid), .req_ack(req_ack),
    .req_read_not_write(req_read_not_write), .req_address(req_address),
    .req_burst_length(req_burst_length), .req_byte_enables(req_byte_enables),
    .wr_data_valid(wr_data_valid), .wr_data(wr_data), .wr_data_ack(wr_data_ack),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_last(rd_last),
    .sram_read_not_write(sram_read_not_write), .sram_write_enable(sram_write_enable),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data)
  );

  // SRAM macro: byte-lane writes, one-cycle registered read.
  logic [31:0] mem [2048];
  always @(posedge clk) begin
    if (!sram_read_not_write)
      for (int b = 0; b < 4; b++)
        if (sram_write_enable[b]) mem[sram_address][8*b +: 8] <= sram_write_data[8*b +: 8];
    sram_read_data <= mem[sram_address];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cyc; logic [31:0] data; logic last; } ret_t;
  ret_t        rq[$];
  ret_t        obs[$];
  ret_t        tmp;
  logic [31:0] ref_mem [2048];
  int          cyc = 0;
  int          rd_first = -1, rd_lastc = -1, rd_base = 0;
  int          wr_rem = 0, wr_start = 0;
  logic [10:0] wr_addr = 11'd0, m_hold = 11'd0;
  logic [3:0]  wr_be = 4'h0;
  logic        rd_act, wr_act;
  logic        e_ack, e_wack, e_rnw, e_rv, e_rl;
  logic [3:0]  e_we;
  logic [10:0] e_addr;
  logic [31:0] e_wd, e_rd;
  int          acc_cyc = 0, wack_cnt = 0, last_wack_cyc = 0;
  logic [10:0] wlog[$];

  always @(negedge clk) begin
    e_ack = 0; e_wack = 0; e_rnw = 1; e_we = 4'h0; e_addr = m_hold; e_wd = 32'h0;
    rd_act = (rd_first >= 0) && (cyc >= rd_first) && (cyc <= rd_lastc);
    wr_act = (wr_rem > 0) && (cyc > wr_start);
    if (sram_reset) e_addr = 11'd0;
    else if (rd_act) e_addr = 11'(rd_base + cyc - rd_first);
    else if (wr_act) begin
      e_addr = wr_addr;
      if (wr_data_valid) begin
        e_rnw = 0; e_we = wr_be; e_wd = wr_data; e_wack = 1;
      end
    end else e_ack = req_valid;

    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      e_rv = 1; e_rd = rq[0].data; e_rl = rq[0].last;
      void'(rq.pop_front());
    end else begin
      e_rv = 0; e_rd = 32'h0; e_rl = 0;
    end

    chk("req_ack", req_ack, e_ack);
    chk("wr_data_ack", wr_data_ack, e_wack);
    chk("sram_rnw", sram_read_not_write, e_rnw);
    chk("sram_we", sram_write_enable, e_we);
    chk("sram_addr", sram_address, e_addr);
    chk("sram_wdata", sram_write_data, e_wd);
    chk("rd_valid", rd_data_valid, e_rv);
    chk("rd_data", rd_data, e_rd);
    chk("rd_last", rd_last, e_rl);

    if (rd_data_valid) begin
      tmp.cyc = cyc; tmp.data = rd_data; tmp.last = rd_last;
      obs.push_back(tmp);
    end
    if (wr_data_ack) begin wack_cnt++; last_wack_cyc = cyc; end
    if (!sram_read_not_write) wlog.push_back(sram_address);
    if (req_ack) acc_cyc = cyc;

    if (sram_reset) begin
      rd_first = -1; wr_rem = 0; m_hold = 11'd0;
      while (rq.size() > 0 && rq[$].cyc > cyc) void'(rq.pop_back());
    end else if (rd_act) begin
      m_hold = e_addr;
      if (cyc == rd_lastc) rd_first = -1;
    end else if (wr_act) begin
      m_hold = wr_addr;
      if (wr_data_valid) begin
        for (int b = 0; b < 4; b++)
          if (wr_be[b]) ref_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
        wr_addr = wr_addr + 11'd1;
        wr_rem--;
      end
    end else if (req_valid) begin
      if (req_read_not_write) begin
        rd_first = cyc + 1; rd_lastc = cyc + 1 + int'(req_burst_length);
        rd_base = int'(req_address);
        for (int k = 0; k <= int'(req_burst_length); k++) begin
          tmp.cyc = cyc + 3 + k;
          tmp.data = ref_mem[11'(int'(req_address) + k)];
          tmp.last = (k == int'(req_burst_length));
          rq.push_back(tmp);
        end
      end else begin
        wr_rem = int'(req_burst_length) + 1; wr_start = cyc;
        wr_addr = req_address; wr_be = req_byte_enables;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  logic [31:0] wdat [16];
  logic [10:0] iss  [16];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rnw, input logic [10:0] a, input logic [3:0] len, input logic [3:0] be);
    int n = 0;
    logic got = 0;
    req_valid = 1; req_read_not_write = rnw; req_address = a;
    req_burst_length = len; req_byte_enables = be;
    while (!got && n < 200) begin
      @(negedge clk);
      if (req_ack) got = 1;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL req_timeout actual=no_ack required=ack");
    end
  endtask

  task automatic wr_phase(input int nb, input logic [15:0] pat, input int npat);
    int idx = 0;
    int step = 0;
    while (idx < nb && step < 100) begin
      wr_data_valid = (step < npat) ? pat[step] : 1'b1;
      wr_data = wdat[idx];
      @(negedge clk);
      if (wr_data_ack) idx++;
      @(posedge clk); #1;
      step++;
    end
    wr_data_valid = 0; wr_data = 32'h0;
    if (idx < nb) begin
      checks++; failures++;
      $display("FAIL wr_timeout actual=%0d required=%0d", idx, nb);
    end
  endtask

  task automatic write_burst(input logic [10:0] a, input int nb, input logic [3:0] be);
    req(1'b0, a, 4'(nb - 1), be);
    wr_phase(nb, 16'hFFFF, 0);
  endtask

  task automatic rd_burst(input logic [10:0] a, input int nb, output int acc, output int base);
    base = obs.size();
    req(1'b1, a, 4'(nb - 1), 4'h0);
    acc = acc_cyc;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk); iss[i] = sram_address;
      @(posedge clk); #1;
    end
    tick(4);
  endtask

  int a, base, wb, ab;

  initial begin
    for (int i = 0; i < 2048; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    sram_reset = 1; req_valid = 0; req_read_not_write = 0; req_address = 0;
    req_burst_length = 0; req_byte_enables = 0; wr_data_valid = 0; wr_data = 0;
    tick(2);
    sram_reset = 0;
    @(negedge clk);
    chk("init_rd_valid", rd_data_valid, 0);
    chk("init_addr", sram_address, 0);
    chk("init_rnw", sram_read_not_write, 1);
    @(posedge clk); #1;

    // single write then read
    wdat[0] = 32'hDEADBEEF;
    write_burst(11'd5, 1, 4'hF);
    rd_burst(11'd5, 1, a, base);
    chk("single_count", obs.size() - base, 1);
    chk("single_cycle", obs[base].cyc, a + 3);
    chk("single_data", obs[base].data, 32'hDEADBEEF);
    chk("single_last", obs[base].last, 1);

    // byte enables
    wdat[0] = 32'h11223344;
    write_burst(11'd9, 1, 4'hF);
    wdat[0] = 32'hAABBCCDD;
    write_burst(11'd9, 1, 4'b0101);
    rd_burst(11'd9, 1, a, base);
    chk("byte_en_data", obs[base].data, 32'h11BB33DD);

    // wrap burst
    for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
    write_burst(11'd2046, 4, 4'hF);
    rd_burst(11'd2046, 4, a, base);
    chk("wrap_addr0", iss[0], 11'd2046);
    chk("wrap_addr1", iss[1], 11'd2047);
    chk("wrap_addr2", iss[2], 11'd0);
    chk("wrap_addr3", iss[3], 11'd1);
    chk("wrap_count", obs.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_data", obs[base + i].data, 32'(i + 1));
      chk("wrap_last", obs[base + i].last, (i == 3) ? 1 : 0);
    end

    // write stalls: valid pattern 1,0,0,1,1
    wb = wlog.size(); ab = wack_cnt;
    wdat[0] = 32'hA1; wdat[1] = 32'hB2; wdat[2] = 32'hC3;
    req(1'b0, 11'd100, 4'd2, 4'hF);
    wr_phase(3, 16'h0019, 5);
    req(1'b1, 11'd100, 4'd2, 4'h0);
    chk("stall_idle_next", acc_cyc, last_wack_cyc + 1);
    chk("stall_acks", wack_cnt - ab, 3);
    chk("stall_writes", wlog.size() - wb, 3);
    for (int i = 0; i < 3; i++) chk("stall_addr", wlog[wb + i], 11'(100 + i));
    tick(8);

    // back-to-back read then queued write
    base = obs.size();
    req(1'b1, 11'd2046, 4'd3, 4'h0);
    a = acc_cyc;
    wdat[0] = 32'h77; wdat[1] = 32'h88;
    req(1'b0, 11'd200, 4'd1, 4'hF);
    chk("b2b_accept", acc_cyc, a + 5);
    wr_phase(2, 16'hFFFF, 0);
    tick(4);
    chk("b2b_count", obs.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_data", obs[base + i].data, 32'(i + 1));
      chk("b2b_cycle", obs[base + i].cyc, a + 3 + i);
    end
    rd_burst(11'd200, 2, a, base);
    chk("b2b_wr0", obs[base].data, 32'h77);
    chk("b2b_wr1", obs[base + 1].data, 32'h88);

    // reset mid read burst
    req(1'b1, 11'd0, 4'd15, 4'h0);
    tick(3);
    sram_reset = 1;
    tick(2);
    sram_reset = 0;
    base = obs.size();
    @(negedge clk);
    chk("rst_rd_valid", rd_data_valid, 0);
    chk("rst_rnw", sram_read_not_write, 1);
    chk("rst_we", sram_write_enable, 0);
    chk("rst_addr", sram_address, 0);
    @(posedge clk); #1;
    tick(20);
    chk("rst_no_returns", obs.size() - base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
